// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial converter, MSB first, one bit per shift_en strobe. A one-word holding
// register with valid/ready lets the next word follow the current LSB with no idle bit.
module bit_stream_serializer #(
    parameter int unsigned WIDTH    = 8,
    parameter logic        IDLE_BIT = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             serial_active,
    output logic             word_done
);

    localparam int unsigned   CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [WIDTH-1:0]  r_hold;
    logic              r_hold_full;
    logic [WIDTH-1:0]  r_shift;
    logic [CntW-1:0]   r_bit_cnt;
    logic              r_serial_out;
    logic              r_serial_active;
    logic              r_word_done;

    logic [WIDTH-1:0]  w_shift_next;
    logic [CntW-1:0]   w_cnt_next;
    logic              w_out_next;
    logic              w_active_next;
    logic              w_done_next;
    logic              w_last;
    logic              w_transfer;
    logic              w_accept;

    assign w_last     = (r_bit_cnt == LastCnt);
    assign w_transfer = shift_en && r_hold_full && ((r_state == StIdle) || w_last);
    assign w_accept   = data_valid && !r_hold_full;

    assign data_ready    = !r_hold_full;
    assign serial_out    = r_serial_out;
    assign serial_active = r_serial_active;
    assign word_done     = r_word_done;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (shift_en) begin
            unique case (r_state)
                StIdle:  if (r_hold_full) w_state_next = StShift;
                StShift: if (w_last && !r_hold_full) w_state_next = StIdle;
                default: w_state_next = StIdle;
            endcase
        end
    end

    // Registered outputs are computed one edge ahead so they line up with the shifter.
    always_comb begin
        w_shift_next  = r_shift;
        w_cnt_next    = r_bit_cnt;
        w_out_next    = r_serial_out;
        w_active_next = r_serial_active;
        w_done_next   = r_word_done;
        if (w_transfer) begin
            w_shift_next  = r_hold;
            w_cnt_next    = '0;
            w_out_next    = r_hold[WIDTH-1];
            w_active_next = 1'b1;
            w_done_next   = 1'b0;
        end else if (shift_en && (r_state == StShift)) begin
            if (!w_last) begin
                // Rotate rather than shift; the wrapped bit is never observed.
                w_shift_next  = {r_shift[WIDTH-2:0], r_shift[WIDTH-1]};
                w_cnt_next    = r_bit_cnt + CntW'(1);
                w_out_next    = r_shift[WIDTH-2];
                w_done_next   = ((r_bit_cnt + CntW'(1)) == LastCnt);
            end else begin
                w_out_next    = IDLE_BIT;
                w_active_next = 1'b0;
                w_done_next   = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_accept) begin
            r_hold      <= data_in;
            r_hold_full <= 1'b1;
        end else if (w_transfer) begin
            r_hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_shift         <= '0;
            r_bit_cnt       <= '0;
            r_serial_out    <= IDLE_BIT;
            r_serial_active <= 1'b0;
            r_word_done     <= 1'b0;
        end else begin
            r_shift         <= w_shift_next;
            r_bit_cnt       <= w_cnt_next;
            r_serial_out    <= w_out_next;
            r_serial_active <= w_active_next;
            r_word_done     <= w_done_next;
        end
    end

endmodule
